// File: rtl/bp_cfg_ctrl.sv
// bp_cfg_ctrl: per-core boot configuration block. A register-mapped command
// port drives freeze, config index, boot PC and cache modes. A small
// sequencer releases unfrozen cores one at a time, lowest index first.
module bp_cfg_ctrl #(
  parameter int          num_core_p    = 4,
  parameter int          num_cfgs_p    = 9,
  parameter int          default_cfg_p = 2,
  parameter int          vaddr_width_p = 39,
  parameter logic [63:0] boot_pc_p     = 64'h0000_0000_0008_0000,
  parameter int          stagger_p     = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_w_i,
  input  logic [7:0]               cmd_addr_i,
  input  logic [63:0]              cmd_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [63:0]              resp_data_o,
  output logic                     resp_err_o,
  output logic [num_core_p-1:0]    freeze_o,
  output logic [6:0]               cfg_id_o,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic [1:0]               icache_mode_o,
  output logic [1:0]               dcache_mode_o
);

  localparam logic [0:0] seq_idle_c = 1'b0;
  localparam logic [0:0] seq_wait_c = 1'b1;

  localparam logic [7:0] addr_freeze_c = 8'h00;
  localparam logic [7:0] addr_cfg_c    = 8'h08;
  localparam logic [7:0] addr_npc_c    = 8'h10;
  localparam logic [7:0] addr_icache_c = 8'h18;
  localparam logic [7:0] addr_dcache_c = 8'h20;
  localparam logic [7:0] addr_status_c = 8'h28;

  localparam logic [7:0]               num_cfgs_c    = 8'(num_cfgs_p);
  localparam logic [6:0]               default_cfg_c = 7'(default_cfg_p);
  localparam logic [7:0]               stagger_m1_c  = 8'(stagger_p - 1);
  localparam logic [vaddr_width_p-1:0] boot_pc_c     = vaddr_width_p'(boot_pc_p);

  logic [num_core_p-1:0]    freeze_q, freeze_d;
  logic [num_core_p-1:0]    release_q, release_d;
  logic [6:0]               cfg_id_q, cfg_id_d;
  logic [vaddr_width_p-1:0] npc_q, npc_d;
  logic [1:0]               icache_mode_q, icache_mode_d;
  logic [1:0]               dcache_mode_q, dcache_mode_d;
  logic [0:0]               seq_state_q, seq_state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     resp_v_q, resp_v_d;
  logic                     resp_err_q, resp_err_d;
  logic [63:0]              resp_data_q, resp_data_d;

  logic                  accept_s;
  logic [num_core_p-1:0] elig_s;
  logic                  any_elig_s;
  logic [num_core_p-1:0] pick_s;
  logic                  pick_found_s;
  logic [num_core_p-1:0] seq_release_s;
  logic                  all_frozen_s;
  logic                  cfg_ok_s;
  logic                  unused_s;

  // A core stays frozen until it is both unfrozen by software and released.
  assign freeze_o      = freeze_q | ~release_q;
  assign cfg_id_o      = cfg_id_q;
  assign npc_o         = npc_q;
  assign icache_mode_o = icache_mode_q;
  assign dcache_mode_o = dcache_mode_q;
  assign resp_v_o      = resp_v_q;
  assign resp_err_o    = resp_err_q;
  assign resp_data_o   = resp_data_q;

  // Single-entry response buffer: ready depends only on the buffer state.
  assign cmd_ready_o = ~resp_v_q;
  assign accept_s    = cmd_v_i & ~resp_v_q;

  assign elig_s       = ~freeze_q & ~release_q;
  assign any_elig_s   = |elig_s;
  assign all_frozen_s = &freeze_o;
  // Config writes need a legal nonzero index and every core held frozen.
  assign cfg_ok_s     = (cmd_data_i[6:0] != 7'd0) &&
                        ({1'b0, cmd_data_i[6:0]} < num_cfgs_c) && all_frozen_s;
  // Write data above each field width is intentionally dropped.
  assign unused_s     = ^cmd_data_i;

  // Pick the lowest-index core waiting for release.
  always_comb begin
    pick_s       = '0;
    pick_found_s = 1'b0;
    for (int i = 0; i < num_core_p; i++) begin
      if (elig_s[i] && !pick_found_s) begin
        pick_s[i]    = 1'b1;
        pick_found_s = 1'b1;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Release sequencer: wait stagger_p cycles, then release one eligible core.
  always_comb begin
    seq_state_d   = seq_state_q;
    cnt_d         = cnt_q;
    seq_release_s = '0;
    case (seq_state_q)
      seq_idle_c: begin
        if (any_elig_s) begin
          seq_state_d = seq_wait_c;
          cnt_d       = stagger_m1_c;
        end else begin
          seq_state_d = seq_idle_c;
        end
      end
      seq_wait_c: begin
        if (!any_elig_s) begin
          seq_state_d = seq_idle_c;
        end else if (cnt_q == 8'd0) begin
          seq_release_s = pick_s;
          seq_state_d   = seq_idle_c;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        seq_state_d = seq_idle_c;
        cnt_d       = 8'd0;
      end
    endcase
  end

  // Command decode, register updates and response buffer next state.
  always_comb begin
    freeze_d      = freeze_q;
    release_d     = release_q | seq_release_s;
    cfg_id_d      = cfg_id_q;
    npc_d         = npc_q;
    icache_mode_d = icache_mode_q;
    dcache_mode_d = dcache_mode_q;
    resp_v_d      = resp_v_q;
    resp_err_d    = resp_err_q;
    resp_data_d   = resp_data_q;
    if (accept_s) begin
      resp_v_d    = 1'b1;
      resp_err_d  = 1'b0;
      resp_data_d = 64'd0;
      if (cmd_addr_i[2:0] != 3'b000) begin
        resp_err_d = 1'b1;
      end else begin
        case (cmd_addr_i)
          addr_freeze_c: begin
            if (cmd_w_i) begin
              freeze_d  = cmd_data_i[num_core_p-1:0];
              // Refreezing a core revokes its release in the same update.
              release_d = release_d & ~cmd_data_i[num_core_p-1:0];
            end else begin
              resp_data_d[num_core_p-1:0] = freeze_q;
            end
          end
          addr_cfg_c: begin
            if (cmd_w_i) begin
              if (cfg_ok_s) begin
                cfg_id_d = cmd_data_i[6:0];
              end else begin
                resp_err_d = 1'b1;
              end
            end else begin
              resp_data_d[6:0] = cfg_id_q;
            end
          end
          addr_npc_c: begin
            if (cmd_w_i) begin
              if (all_frozen_s) begin
                npc_d = cmd_data_i[vaddr_width_p-1:0];
              end else begin
                resp_err_d = 1'b1;
              end
            end else begin
              resp_data_d[vaddr_width_p-1:0] = npc_q;
            end
          end
          addr_icache_c: begin
            if (cmd_w_i) begin
              icache_mode_d = cmd_data_i[1:0];
            end else begin
              resp_data_d[1:0] = icache_mode_q;
            end
          end
          addr_dcache_c: begin
            if (cmd_w_i) begin
              dcache_mode_d = cmd_data_i[1:0];
            end else begin
              resp_data_d[1:0] = dcache_mode_q;
            end
          end
          addr_status_c: begin
            if (cmd_w_i) begin
              resp_err_d = 1'b1;
            end else begin
              resp_data_d[num_core_p-1:0] = release_q;
              resp_data_d[32]             = (seq_state_q == seq_wait_c);
            end
          end
          default: begin
            resp_err_d = 1'b1;
          end
        endcase
      end
    end else if (resp_yumi_i) begin
      resp_v_d = 1'b0;
    end else begin
      resp_v_d = resp_v_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freeze_q      <= '1;
      release_q     <= '0;
      cfg_id_q      <= default_cfg_c;
      npc_q         <= boot_pc_c;
      icache_mode_q <= 2'd0;
      dcache_mode_q <= 2'd0;
      seq_state_q   <= seq_idle_c;
      cnt_q         <= 8'd0;
      resp_v_q      <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= 64'd0;
    end else begin
      freeze_q      <= freeze_d;
      release_q     <= release_d;
      cfg_id_q      <= cfg_id_d;
      npc_q         <= npc_d;
      icache_mode_q <= icache_mode_d;
      dcache_mode_q <= dcache_mode_d;
      seq_state_q   <= seq_state_d;
      cnt_q         <= cnt_d;
      resp_v_q      <= resp_v_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_bp_cfg_ctrl.sv
// Directed bench for bp_cfg_ctrl with default parameters.
module tb_bp_cfg_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic        cmd_w_i;
  logic [7:0]  cmd_addr_i;
  logic [63:0] cmd_data_i;
  logic        resp_v_o;
  logic        resp_yumi_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic [3:0]  freeze_o;
  logic [6:0]  cfg_id_o;
  logic [38:0] npc_o;
  logic [1:0]  icache_mode_o;
  logic [1:0]  dcache_mode_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        w;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        exp_err;
    logic [63:0] exp_data;
    logic [6:0]  exp_cfg;
  } vec_t;

  vec_t vecs[$];

  bp_cfg_ctrl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_w_i       (cmd_w_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_data_i    (cmd_data_i),
    .resp_v_o      (resp_v_o),
    .resp_yumi_i   (resp_yumi_i),
    .resp_data_o   (resp_data_o),
    .resp_err_o    (resp_err_o),
    .freeze_o      (freeze_o),
    .cfg_id_o      (cfg_id_o),
    .npc_o         (npc_o),
    .icache_mode_o (icache_mode_o),
    .dcache_mode_o (dcache_mode_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one command, collect its response, then pop it with yumi.
  task automatic do_cmd(input logic w, input logic [7:0] a, input logic [63:0] d,
                        output logic err, output logic [63:0] data);
    int n;
    n          = 0;
    cmd_w_i    = w;
    cmd_addr_i = a;
    cmd_data_i = d;
    cmd_v_i    = 1'b1;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_ready_o) begin
      failures++;
      $display("FAIL cmd_ready_timeout addr=0x%0h", a);
    end
    tick();
    cmd_v_i = 1'b0;
    chk("resp_v_after_accept", {63'd0, resp_v_o}, 64'd1);
    err  = resp_err_o;
    data = resp_data_o;
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
  endtask

  logic        r_err;
  logic [63:0] r_data;
  int          nrel;

  initial begin
    reset_i     = 1'b1;
    cmd_v_i     = 1'b0;
    cmd_w_i     = 1'b0;
    cmd_addr_i  = 8'h00;
    cmd_data_i  = 64'd0;
    resp_yumi_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Reset state.
    chk("rst_freeze", {60'd0, freeze_o}, 64'hF);
    chk("rst_resp_v", {63'd0, resp_v_o}, 64'd0);
    chk("rst_ready", {63'd0, cmd_ready_o}, 64'd1);
    chk("rst_cfg", {57'd0, cfg_id_o}, 64'd2);
    chk("rst_npc", {25'd0, npc_o}, 64'h80000);
    chk("rst_icache", {62'd0, icache_mode_o}, 64'd0);
    chk("rst_dcache", {62'd0, dcache_mode_o}, 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);

    // Register map vectors, all cores frozen.
    vecs.push_back('{1'b0, 8'h08, 64'd0, 1'b0, 64'd2, 7'd2});
    vecs.push_back('{1'b0, 8'h10, 64'd0, 1'b0, 64'h80000, 7'd2});
    vecs.push_back('{1'b0, 8'h00, 64'd0, 1'b0, 64'hF, 7'd2});
    vecs.push_back('{1'b0, 8'h18, 64'd0, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h18, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h18, 64'd0, 1'b0, 64'd2, 7'd2});
    vecs.push_back('{1'b1, 8'h20, 64'd1, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h20, 64'd0, 1'b0, 64'd1, 7'd2});
    vecs.push_back('{1'b1, 8'h28, 64'd5, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h28, 64'd0, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h30, 64'd0, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h0C, 64'd0, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h09, 64'd7, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h08, 64'd0, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h08, 64'd9, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h08, 64'd8, 1'b0, 64'd0, 7'd8});
    vecs.push_back('{1'b0, 8'h08, 64'd0, 1'b0, 64'd8, 7'd8});
    vecs.push_back('{1'b1, 8'h08, 64'd2, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h10, 64'd0, 1'b0, 64'h7F_FFFF_FFFF, 7'd2});
    vecs.push_back('{1'b0, 8'hFF, 64'd0, 1'b1, 64'd0, 7'd2});
    vecs.push_back('{1'b0, 8'h38, 64'd0, 1'b1, 64'd0, 7'd2});

    foreach (vecs[i]) begin
      do_cmd(vecs[i].w, vecs[i].addr, vecs[i].data, r_err, r_data);
      chk($sformatf("vec%0d_err", i), {63'd0, r_err}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_data", i), r_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_cfg", i), {57'd0, cfg_id_o}, {57'd0, vecs[i].exp_cfg});
    end
    chk("npc_out", {25'd0, npc_o}, 64'h7F_FFFF_FFFF);
    chk("icache_out", {62'd0, icache_mode_o}, 64'd2);
    chk("dcache_out", {62'd0, dcache_mode_o}, 64'd1);

    // Staggered release: core0 after 5 cycles, then every 5 cycles.
    do_cmd(1'b1, 8'h00, 64'd0, r_err, r_data);
    chk("rel_k1", {60'd0, freeze_o}, 64'hF);
    for (int k = 2; k <= 24; k++) begin
      tick();
      nrel = k / 5;
      if (nrel > 4) nrel = 4;
      chk($sformatf("rel_k%0d", k), {60'd0, freeze_o}, 64'((15 >> nrel) << nrel));
    end
    do_cmd(1'b0, 8'h28, 64'd0, r_err, r_data);
    chk("status_all_rel", r_data, 64'hF);

    // Config and NPC writes while cores run are rejected.
    do_cmd(1'b1, 8'h08, 64'd3, r_err, r_data);
    chk("cfg_run_err", {63'd0, r_err}, 64'd1);
    chk("cfg_run_keep", {57'd0, cfg_id_o}, 64'd2);
    do_cmd(1'b1, 8'h10, 64'h1234, r_err, r_data);
    chk("npc_run_err", {63'd0, r_err}, 64'd1);
    chk("npc_run_keep", {25'd0, npc_o}, 64'h7F_FFFF_FFFF);
    do_cmd(1'b1, 8'h00, 64'hF, r_err, r_data);
    chk("refreeze_err", {63'd0, r_err}, 64'd0);
    chk("refreeze_out", {60'd0, freeze_o}, 64'hF);
    do_cmd(1'b1, 8'h08, 64'd3, r_err, r_data);
    chk("cfg_frz_err", {63'd0, r_err}, 64'd0);
    chk("cfg_frz_val", {57'd0, cfg_id_o}, 64'd3);

    // Backpressure: response held, second command not accepted.
    cmd_w_i    = 1'b0;
    cmd_addr_i = 8'h08;
    cmd_v_i    = 1'b1;
    tick();
    cmd_w_i    = 1'b1;
    cmd_data_i = 64'd5;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", {63'd0, cmd_ready_o}, 64'd0);
      chk("bp_resp_v", {63'd0, resp_v_o}, 64'd1);
      chk("bp_data", resp_data_o, 64'd3);
      chk("bp_err", {63'd0, resp_err_o}, 64'd0);
      tick();
    end
    cmd_v_i     = 1'b0;
    resp_yumi_i = 1'b1;
    tick();
    resp_yumi_i = 1'b0;
    chk("bp_resp_drop", {63'd0, resp_v_o}, 64'd0);
    chk("bp_cfg_keep", {57'd0, cfg_id_o}, 64'd3);

    // Refreeze mid-WAIT, racing the core1 release edge.
    do_cmd(1'b1, 8'h00, 64'd0, r_err, r_data);
    for (int k = 2; k <= 7; k++) tick();
    do_cmd(1'b0, 8'h28, 64'd0, r_err, r_data);
    chk("status_busy", r_data, 64'h1_0000_0001);
    do_cmd(1'b1, 8'h00, 64'hF, r_err, r_data);
    chk("midwait_refreeze", {60'd0, freeze_o}, 64'hF);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("refreeze_hold", {60'd0, freeze_o}, 64'hF);
    end
    do_cmd(1'b0, 8'h28, 64'd0, r_err, r_data);
    chk("status_idle", r_data, 64'd0);

    // Reset mid-WAIT with a pending response.
    do_cmd(1'b1, 8'h00, 64'd0, r_err, r_data);
    for (int k = 2; k <= 7; k++) tick();
    chk("pre_rst_freeze", {60'd0, freeze_o}, 64'hE);
    cmd_w_i    = 1'b0;
    cmd_addr_i = 8'h08;
    cmd_v_i    = 1'b1;
    tick();
    cmd_v_i = 1'b0;
    chk("pend_resp_v", {63'd0, resp_v_o}, 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("mrst_resp_v", {63'd0, resp_v_o}, 64'd0);
    chk("mrst_ready", {63'd0, cmd_ready_o}, 64'd1);
    chk("mrst_freeze", {60'd0, freeze_o}, 64'hF);
    chk("mrst_cfg", {57'd0, cfg_id_o}, 64'd2);
    chk("mrst_npc", {25'd0, npc_o}, 64'h80000);
    chk("mrst_icache", {62'd0, icache_mode_o}, 64'd0);
    chk("mrst_dcache", {62'd0, dcache_mode_o}, 64'd0);
    chk("mrst_err", {63'd0, resp_err_o}, 64'd0);
    chk("mrst_data", resp_data_o, 64'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("mrst_hold_freeze", {60'd0, freeze_o}, 64'hF);
      chk("mrst_hold_resp", {63'd0, resp_v_o}, 64'd0);
    end
    do_cmd(1'b0, 8'h28, 64'd0, r_err, r_data);
    chk("mrst_status", r_data, 64'd0);
    do_cmd(1'b0, 8'h00, 64'd0, r_err, r_data);
    chk("mrst_freeze_reg", r_data, 64'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
